decodificador_binario_decimal: RTL and testbench

//   Registered binary-to-decimal decoder driving one 7-segment digit.

---
 rtl/decodificador_binario_decimal.sv | 57 +++++
 tb/tb_decodificador_binario_decimal.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/decodificador_binario_decimal.sv
// Registered 4-bit binary to 7-segment decimal decoder with an error flag for codes 10..15.
// Segment order is S[6:0] = abcdefg. COMMON_ANODE inverts every segment, including the reset pattern.
module decodificador_binario_decimal #(
    parameter bit COMMON_ANODE  = 1'b0,
    parameter bit BLANK_INVALID = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    output logic [6:0] S,
    output logic       ERR
);

    localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'b1111111 : 7'b0000000;

    logic [6:0] seg_raw;
    logic [6:0] seg_d, seg_q;
    logic       err_d, err_q;

    // Active-high (common-cathode) pattern; polarity is applied afterwards.
    always_comb begin
        seg_raw = 7'b0000000;
        err_d   = 1'b0;
        case (A)
            4'd0: seg_raw = 7'b1111110;
            4'd1: seg_raw = 7'b0110000;
            4'd2: seg_raw = 7'b1101101;
            4'd3: seg_raw = 7'b1111001;
            4'd4: seg_raw = 7'b0110011;
            4'd5: seg_raw = 7'b1011011;
            4'd6: seg_raw = 7'b1011111;
            4'd7: seg_raw = 7'b1110000;
            4'd8: seg_raw = 7'b1111111;
            4'd9: seg_raw = 7'b1111011;
            default: begin
                seg_raw = BLANK_INVALID ? 7'b0000000 : 7'b0000001;
                err_d   = 1'b1;
            end
        endcase
        seg_d = COMMON_ANODE ? ~seg_raw : seg_raw;
    end

    // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
            err_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            err_q <= err_d;
        end
    end

    assign S   = seg_q;
    assign ERR = err_q;

endmodule

// File: tb/tb_decodificador_binario_decimal.sv
// Scoreboard bench for the decoder: three instances (cathode/blank, cathode/dash, anode/blank)
// share one stimulus stream; expected values are queued at drive time and checked after each edge.
module tb_decodificador_binario_decimal;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A;
    logic [6:0] s_cc, s_dash, s_ca;
    logic       err_cc, err_dash, err_ca;

    decodificador_binario_decimal #(.COMMON_ANODE(1'b0), .BLANK_INVALID(1'b1)) u_cc (
        .clk(clk), .rst_n(rst_n), .A(A), .S(s_cc), .ERR(err_cc));
    decodificador_binario_decimal #(.COMMON_ANODE(1'b0), .BLANK_INVALID(1'b0)) u_dash (
        .clk(clk), .rst_n(rst_n), .A(A), .S(s_dash), .ERR(err_dash));
    decodificador_binario_decimal #(.COMMON_ANODE(1'b1), .BLANK_INVALID(1'b1)) u_ca (
        .clk(clk), .rst_n(rst_n), .A(A), .S(s_ca), .ERR(err_ca));

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] s_cc;
        logic [6:0] s_dash;
        logic [6:0] s_ca;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [6:0] ref_seg(input logic [3:0] code, input bit dash);
        case (code)
            4'd0: return 7'h7E;
            4'd1: return 7'h30;
            4'd2: return 7'h6D;
            4'd3: return 7'h79;
            4'd4: return 7'h33;
            4'd5: return 7'h5B;
            4'd6: return 7'h5F;
            4'd7: return 7'h70;
            4'd8: return 7'h7F;
            4'd9: return 7'h7B;
            default: return dash ? 7'h01 : 7'h00;
        endcase
    endfunction

    // Drive inputs now and queue what the outputs must show after the next rising edge.
    task automatic drive(input logic r, input logic [3:0] a, input string tag);
        exp_t e;
        A     = a;
        rst_n = r;
        e.tag = tag;
        if (!r) begin
            e.s_cc   = 7'h00;
            e.s_dash = 7'h00;
            e.s_ca   = 7'h7F;
            e.err    = 1'b0;
        end else begin
            e.s_cc   = ref_seg(a, 1'b0);
            e.s_dash = ref_seg(a, 1'b1);
            e.s_ca   = ~ref_seg(a, 1'b0);
            e.err    = (a > 4'd9);
        end
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        vectors++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got nothing queued, required one entry");
            miscompares++;
            return;
        end
        e = sb.pop_front();
        if (s_cc !== e.s_cc) begin
            $display("FAIL %s S(cc): got %h, required %h", e.tag, s_cc, e.s_cc);
            miscompares++;
        end
        if (s_dash !== e.s_dash) begin
            $display("FAIL %s S(dash): got %h, required %h", e.tag, s_dash, e.s_dash);
            miscompares++;
        end
        if (s_ca !== e.s_ca) begin
            $display("FAIL %s S(ca): got %h, required %h", e.tag, s_ca, e.s_ca);
            miscompares++;
        end
        if (err_cc !== e.err || err_dash !== e.err || err_ca !== e.err) begin
            $display("FAIL %s ERR: got %b/%b/%b, required %b", e.tag, err_cc, err_dash, err_ca, e.err);
            miscompares++;
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] a, input string tag);
        @(negedge clk);
        drive(r, a, tag);
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) apply(1'b0, 4'd8, "reset");
    endtask

    task automatic test_sweep();
        for (int d = 0; d < 10; d++)
            for (int c = 0; c < 10; c++) apply(1'b1, 4'(d), "sweep");
    endtask

    task automatic test_latency();
        apply(1'b1, 4'd3, "latency_pre");
        #2;
        A = 4'd4;
        #1;
        vectors++;
        if (s_cc !== 7'h79) begin
            $display("FAIL latency_hold: got %h before edge, required 79", s_cc);
            miscompares++;
        end
        drive(1'b1, 4'd4, "latency_post");
        step();
    endtask

    task automatic test_invalid();
        for (int c = 10; c < 16; c++) apply(1'b1, 4'(c), "invalid");
        apply(1'b1, 4'd0, "invalid_recover");
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 4'd5, "mid_show5");
        apply(1'b0, 4'd5, "mid_reset");
        apply(1'b1, 4'd5, "mid_release");
    endtask

    task automatic test_common_anode();
        apply(1'b1, 4'd0, "ca_zero");
        apply(1'b1, 4'd8, "ca_eight");
        apply(1'b0, 4'd8, "ca_reset");
    endtask

    task automatic test_boundaries();
        apply(1'b1, 4'd9, "bound_9");
        apply(1'b1, 4'd10, "bound_10");
        apply(1'b1, 4'd15, "bound_15");
        apply(1'b1, 4'd0, "bound_15_to_0");
        for (int i = 0; i < 4; i++) apply(1'b1, 4'd6, "hold");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            apply(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), "random");
    endtask

    initial begin
        rst_n = 1'b0;
        A     = 4'd8;
        test_reset();
        test_sweep();
        test_latency();
        test_invalid();
        test_reset_mid();
        test_common_anode();
        test_boundaries();
        test_random();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
